// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter that time-shares one registered AND/OR/XOR/NAND unit among N requesters.
// Every transaction walks IDLE -> EXEC -> DONE, so at most one operation completes every three cycles.
module logic_unit_arbiter #(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req,
    input  logic [2*N-1:0]     op,
    input  logic [N*WIDTH-1:0] a_in,
    input  logic [N*WIDTH-1:0] b_in,
    output logic [N-1:0]       gnt,
    output logic [N-1:0]       done,
    output logic [WIDTH-1:0]   result,
    output logic               busy,
    output logic [1:0]         dbg_state
);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Handshake: requester i raises req[i] with its op/operands and holds it; the edge that sets
    // gnt[i] captures those operands, done[i] pulses for one cycle with result valid, and req[i]
    // must be low by the following edge or it counts as a fresh request.

    state_e            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     id_q, id_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [1:0]        op_q, op_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic [N-1:0]      done_q, done_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              busy_q, busy_d;

    logic              win_found;
    logic [IW-1:0]     win_id;
    logic [WIDTH-1:0]  a_sel;
    logic [WIDTH-1:0]  b_sel;
    logic [1:0]        op_sel;
    logic [WIDTH-1:0]  lu_out;

    // Scan starts at ptr and wraps, so the most recently served requester has lowest priority.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_id    = IW'(idx);
            end
        end
    end

    always_comb begin
        a_sel  = a_in[WIDTH*win_id +: WIDTH];
        b_sel  = b_in[WIDTH*win_id +: WIDTH];
        op_sel = op[2*win_id +: 2];
    end

    always_comb begin
        lu_out = '0;
        unique case (op_q)
            2'b00: lu_out = a_q & b_q;
            2'b01: lu_out = a_q | b_q;
            2'b10: lu_out = a_q ^ b_q;
            2'b11: lu_out = ~(a_q & b_q);
            default: lu_out = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        gnt_d    = gnt_q;
        done_d   = done_q;
        result_d = result_q;
        busy_d   = busy_q;

        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d       = EXEC;
                    id_d          = win_id;
                    a_d           = a_sel;
                    b_d           = b_sel;
                    op_d          = op_sel;
                    gnt_d         = '0;
                    gnt_d[win_id] = 1'b1;
                    ptr_d         = (win_id == IW'(N - 1)) ? '0 : win_id + 1'b1;
                    busy_d        = 1'b1;
                end
            end
            EXEC: begin
                state_d      = DONE;
                result_d     = lu_out;
                done_d       = '0;
                done_d[id_q] = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
                done_d  = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                done_d  = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            id_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            busy_q   <= busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign result    = result_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule
